// File: rtl/sub_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sub_pkg
// Purpose : Shared definitions for the bit-serial (nibble-serial) subtractor.
//           Provides the slice width and the controller state encoding.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package sub_pkg;

    // Width of one arithmetic step of the serial subtractor.
    localparam int C_SLICE_W = 4;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : sub_pkg
`default_nettype wire

// File: rtl/slice_sub4.sv
`default_nettype none
// ============================================================================
// Module  : slice_sub4
// Purpose : Combinational 4-bit subtract slice. Computes a4 + ~b4 + cin, so a
//           chain started with cin=1 yields a - b in two's complement.
// Ports   : a4   - minuend slice
//           b4   - subtrahend slice (inverted internally)
//           cin  - carry in (1 = no borrow pending)
//           d4   - difference slice
//           cout - carry out (0 = borrow out)
// Revision: 1.0 - initial release
// ============================================================================
module slice_sub4
    import sub_pkg::*;
(
    input  logic [C_SLICE_W-1:0] a4,
    input  logic [C_SLICE_W-1:0] b4,
    input  logic                 cin,
    output logic [C_SLICE_W-1:0] d4,
    output logic                 cout
);

    logic [C_SLICE_W:0] w_sum;

    assign w_sum = {1'b0, a4} + {1'b0, ~b4} + {{C_SLICE_W{1'b0}}, cin};
    assign d4    = w_sum[C_SLICE_W-1:0];
    assign cout  = w_sum[C_SLICE_W];

endmodule : slice_sub4
`default_nettype wire

// File: rtl/sub_serial.sv
`default_nettype none
// ============================================================================
// Module  : sub_serial
// Purpose : Nibble-serial subtractor. Accepts a and b with a valid/ready
//           handshake, computes a - b one 4-bit slice per cycle (LSB first)
//           using a single reused slice_sub4, then presents diff/borrow until
//           the consumer accepts the result.
// Config  : define SUB_FLAGS_EN to add the registered zero and ovf outputs.
// Ports   : clk       - clock, rising edge
//           rst_n     - synchronous active-low reset
//           in_valid  - operands valid          in_ready  - operands accepted
//           a, b      - minuend / subtrahend
//           out_valid - result valid            out_ready - result consumed
//           diff      - a - b mod 2^WIDTH       borrow    - unsigned a < b
//           zero, ovf - diff==0 / signed overflow (SUB_FLAGS_EN only)
// Revision: 1.0 - initial release
// ============================================================================
module sub_serial
    import sub_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SUB_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    localparam int NSLICE = WIDTH / C_SLICE_W;
    localparam int CNT_W  = $clog2(NSLICE);

    localparam logic [CNT_W-1:0] c_last_slice = CNT_W'(NSLICE - 1);
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

    state_t               r_state;
    state_t               w_state_nxt;

    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_diff;
    logic                 r_carry;
    logic                 r_borrow;
    logic [CNT_W-1:0]     r_cnt;

    logic                 w_last;
    logic [CNT_W+1:0]     w_base;
    logic [C_SLICE_W-1:0] w_d4;
    logic                 w_cout;

    assign w_last = (r_cnt == c_last_slice);
    // Bit offset of the current slice: r_cnt * 4.
    assign w_base = {r_cnt, 2'b00};

    slice_sub4 u_slice (
        .a4   (r_a[w_base +: C_SLICE_W]),
        .b4   (r_b[w_base +: C_SLICE_W]),
        .cin  (r_carry),
        .d4   (w_d4),
        .cout (w_cout)
    );

    // ------------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: operands are captured once; diff is only written in RUN so it
    // holds its value through DONE and IDLE.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_diff[w_base +: C_SLICE_W] <= w_d4;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + c_cnt_one;
                    if (w_last) begin
                        // No carry out of the top slice means a < b.
                        r_borrow <= ~w_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign diff   = r_diff;
    assign borrow = r_borrow;

`ifdef SUB_FLAGS_EN
    logic r_zero;
    logic r_ovf;

    // The last RUN cycle writes the top slice, so the final diff is the new
    // top nibble over the already-stored lower bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
        end else if ((r_state == RUN) && w_last) begin
            r_zero <= ({w_d4, r_diff[WIDTH-C_SLICE_W-1:0]} == '0);
            r_ovf  <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                      (w_d4[C_SLICE_W-1] != r_a[WIDTH-1]);
        end
    end

    assign zero = r_zero;
    assign ovf  = r_ovf;
`else
    // Flag outputs and their registers are absent in this build.
`endif

endmodule : sub_serial
`default_nettype wire

// File: tb/tb_sub_serial.sv
`default_nettype none
// ============================================================================
// Module  : tb_sub_serial
// Purpose : Self-checking bench for sub_serial (WIDTH=32). Expected results
//           come from plain arithmetic on the operands (a - b, a < b, signed
//           range test); timing expectations come from the handshake rules.
// Config  : SUB_FLAGS_EN adds checks of zero and ovf.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sub_serial;

    localparam int W      = 32;
    localparam int NSLICE = W / 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  diff;
    logic          borrow;
`ifdef SUB_FLAGS_EN
    logic          zero;
    logic          ovf;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    sub_serial #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
`ifdef SUB_FLAGS_EN
        ,
        .zero      (zero),
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: signed overflow means the true signed difference does not
    // fit in W bits.
    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
        longint d;
        d = longint'($signed(x)) - longint'($signed(y));
        return (d > 64'sd2147483647) || (d < -64'sd2147483648);
    endfunction

    // One full transaction: present operands, wait for the result, check it,
    // keep out_ready low for 'hold' extra DONE cycles, then consume it.
    // With 'noise' set, in_valid/a/b are scrambled while the DUT is busy.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input int hold, input bit noise);
        int            edges;
        logic [W-1:0]  ed;
        logic          eb;
        ed = ta - tb_;
        eb = (ta < tb_);
        check("pre_in_ready", in_ready, 1);
        in_valid  = 1'b1;
        a         = ta;
        b         = tb_;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        check("busy_in_ready", in_ready, 0);
        edges = 0;
        while (!out_valid && edges < 40) begin
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                a        = $urandom;
                b        = $urandom;
            end
            @(posedge clk); #1;
            edges++;
        end
        in_valid = 1'b0;
        // Cycles counted with the accept cycle as cycle 0.
        check("latency", edges + 1, NSLICE + 1);
        for (int i = 0; i <= hold; i++) begin
            check("out_valid", out_valid, 1);
            check("done_in_ready", in_ready, 0);
            check("diff", diff, ed);
            check("borrow", borrow, eb);
`ifdef SUB_FLAGS_EN
            check("zero", zero, (ed == '0));
            check("ovf", ovf, ref_ovf(ta, tb_));
`endif
            if (i < hold) begin
                @(posedge clk); #1;
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_out_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
        check("post_diff_held", diff, ed);
    endtask

    initial begin : stim
        int           seen;
        int           cyc;
        int           got;
        int           acc_t[$];
        logic [W-1:0] exq[$];
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        // Reset
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow, 0);
`ifdef SUB_FLAGS_EN
        check("rst_zero", zero, 0);
        check("rst_ovf", ovf, 0);
`endif

        // Directed corner cases
        do_op(32'h0000_0009, 32'h0000_0004, 0, 1'b0);
        do_op(32'h0000_0000, 32'h0000_0001, 0, 1'b0);
        do_op(32'h8000_0000, 32'h0000_0001, 0, 1'b0);
        do_op(32'h0000_0005, 32'h0000_0007, 0, 1'b0);
        do_op(32'h1234_5678, 32'h1234_5678, 5, 1'b0);
        do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1, 1'b1);

        // Reset while slice 3 is being processed
        in_valid = 1'b1;
        a        = 32'hDEAD_BEEF;
        b        = 32'h0001_2345;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_diff", diff, 0);
        check("abort_borrow", borrow, 0);
        seen = 0;
        repeat (12) begin
            if (out_valid) seen = 1;
            @(posedge clk); #1;
        end
        check("abort_no_result", seen, 0);
        do_op(32'h0000_0010, 32'h0000_0001, 0, 1'b0);

        // Random operands, some with bus noise during the computation
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i == 3) ? ra : W'($urandom);
            do_op(ra, rb, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        // Back-to-back throughput with in_valid and out_ready held high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = $urandom;
        b         = $urandom;
        cyc       = 0;
        got       = 0;
        while (got < 3 && cyc < 100) begin
            seen = 0;
            if (out_valid) begin
                if (exq.size() == 0) begin
                    check("tp_unexpected_result", 1, 0);
                end else begin
                    check("tp_diff", diff, exq.pop_front());
                end
                got++;
            end
            if (in_ready) begin
                acc_t.push_back(cyc);
                exq.push_back(a - b);
                seen = 1;
            end
            @(posedge clk); #1;
            cyc++;
            if (seen != 0) begin
                a = $urandom;
                b = $urandom;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("tp_results", got, 3);
        check("tp_accepts_ge3", (acc_t.size() >= 3), 1);
        for (int i = 1; i < acc_t.size() && i < 3; i++) begin
            check("tp_spacing", acc_t[i] - acc_t[i-1], NSLICE + 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_sub_serial
`default_nettype wire

// File: doc/sub_serial.md
SUB_SERIAL -- requirements
Module: sub_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; legal values are multiples of 4 and at least 8.
REQ-002 SHALL have derived localparam NSLICE = WIDTH/4, the number of 4-bit slice steps.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operands a and b are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts operands.
REQ-007 SHALL have port a, input, WIDTH bits: minuend.
REQ-008 SHALL have port b, input, WIDTH bits: subtrahend.
REQ-009 SHALL have port out_valid, output, 1 bit: result is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port diff, output, WIDTH bits: a - b modulo 2^WIDTH.
REQ-012 SHALL have port borrow, output, 1 bit: high when unsigned a < b.
REQ-013 SHALL have port zero, output, 1 bit, and port ovf, output, 1 bit, present only under SUB_FLAGS_EN.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016 SHALL, in IDLE when in_valid && in_ready, register a, b, load the carry register with 1 and the slice counter with 0, and go to RUN.
REQ-017 SHALL, each RUN cycle, compute slice k as a[4k+3:4k] + ~b[4k+3:4k] + carry; it SHALL store the 4-bit result into diff[4k+3:4k], store the carry-out and increment k.
REQ-018 SHALL go to DONE after the cycle that processes slice NSLICE-1, giving exactly NSLICE RUN cycles; out_valid SHALL rise NSLICE+1 cycles after the accept edge.
REQ-019 SHALL set borrow = NOT final carry-out (a=5, b=7 gives borrow=1; a=b gives borrow=0).
REQ-020 SHALL hold diff, borrow and the flags stable in DONE until out_valid && out_ready, then go to IDLE.
REQ-021 SHALL accept the next operands no earlier than the cycle after the result handshake; back-to-back throughput is 1 result per NSLICE+2 cycles.
REQ-022 SHALL ignore in_valid, a and b while in RUN or DONE.
REQ-023 SHALL leave diff unchanged outside RUN; partially written diff is not observable because out_valid = 0.

Reset
REQ-024 SHALL, on a clk edge with rst_n = 0, force IDLE, in_ready=1 in the following cycle, out_valid=0, diff=0, borrow=0, zero=0, ovf=0, counter=0, carry=0.
REQ-025 SHALL abort any RUN or DONE operation on reset without emitting a result.

Configuration
REQ-026 SHALL, with macro SUB_FLAGS_EN defined, provide zero = (diff == 0) and ovf = signed overflow (a[MSB] != b[MSB] && diff[MSB] != a[MSB]), both registered and valid in DONE.
REQ-027 SHALL, without SUB_FLAGS_EN, omit the zero and ovf ports and their logic entirely; all other behaviour is identical.

Structure
REQ-028 SHALL take the FSM state enum (IDLE/RUN/DONE) and the slice-width constant 4 from the shared package sub_pkg.
REQ-029 SHALL instantiate exactly one combinational sub-module slice_sub4 (inputs a4, b4, cin; outputs d4, cout; it inverts b internally), reused every RUN cycle.

Verification
REQ-030 SHALL cover this scenario: WIDTH=32, a=0x0000_0009, b=0x0000_0004 -> diff=0x0000_0005, borrow=0, out_valid 9 cycles after accept.
REQ-031 SHALL cover this scenario: a=0x0000_0000, b=0x0000_0001 -> diff=0xFFFF_FFFF, borrow=1, ovf=0, zero=0.
REQ-032 SHALL cover this scenario: a=0x8000_0000, b=0x0000_0001 -> diff=0x7FFF_FFFF, borrow=0, ovf=1.
REQ-033 SHALL cover this scenario: a=b=0x1234_5678 with out_ready held low for 5 cycles -> diff=0, zero=1, outputs stable, in_ready=0 throughout.
REQ-034 SHALL cover this scenario: rst_n low for 1 cycle in RUN slice 3 -> next cycle IDLE, out_valid never asserts, then a fresh 0x10-0x01 gives 0x0F.
REQ-035 SHALL cover this scenario: in_valid toggled with new operands during RUN -> result matches the first accepted pair only.
